// File: rtl/decode_pkg.sv
// Shared widths, functional-unit codes and the packed decoded-instruction record
// used by the decode output queue and its neighbours.
package decode_pkg;

  localparam int OPCODE_SIZE               = 12;
  localparam int ADDRESS_WIDTH             = 64;
  localparam int FUNC_UNIT_CODE_SIZE       = 3;
  localparam int INSTRUCTION_COUNTER_WIDTH = 64;
  localparam int INST_MIN_ID_WIDTH         = 7;
  localparam int PID_SIZE                  = 20;
  localparam int TID_SIZE                  = 16;
  localparam int REG_SIZE                  = 5;
  localparam int REG_ACCESS_PATTERN_SIZE   = 2;

  localparam logic [FUNC_UNIT_CODE_SIZE-1:0] FU_FX     = 3'd0;
  localparam logic [FUNC_UNIT_CODE_SIZE-1:0] FU_FP     = 3'd1;
  localparam logic [FUNC_UNIT_CODE_SIZE-1:0] FU_VX     = 3'd2;
  localparam logic [FUNC_UNIT_CODE_SIZE-1:0] FU_CR     = 3'd3;
  localparam logic [FUNC_UNIT_CODE_SIZE-1:0] FU_LS     = 3'd4;
  localparam logic [FUNC_UNIT_CODE_SIZE-1:0] FU_BRANCH = 3'd6;

  // Field order matches the packing order used on the queue storage word.
  typedef struct packed {
    logic [OPCODE_SIZE-1:0]               opcode;
    logic [ADDRESS_WIDTH-1:0]             instruction_address;
    logic [FUNC_UNIT_CODE_SIZE-1:0]       functional_unit_type;
    logic [INSTRUCTION_COUNTER_WIDTH-1:0] inst_maj_id;
    logic [INST_MIN_ID_WIDTH-1:0]         inst_min_id;
    logic                                 is_64bit;
    logic [PID_SIZE-1:0]                  inst_pid;
    logic [TID_SIZE-1:0]                  inst_tid;
    logic [REG_ACCESS_PATTERN_SIZE-1:0]   op1_rw;
    logic [REG_ACCESS_PATTERN_SIZE-1:0]   op2_rw;
    logic [REG_ACCESS_PATTERN_SIZE-1:0]   op3_rw;
    logic [REG_ACCESS_PATTERN_SIZE-1:0]   op4_rw;
    logic                                 op1_is_reg;
    logic                                 op2_is_reg;
    logic                                 op3_is_reg;
    logic                                 op4_is_reg;
    logic [4*REG_SIZE:0]                  instruction_body;
  } decode_inst_t;

  localparam int DECODE_INST_W = $bits(decode_inst_t);

endpackage

// File: rtl/decode_output_queue_if.sv
// Decoded-instruction push side, downstream pop side and queue status, bundled
// for the decode output queue.
interface decode_output_queue_if #(
  parameter int DEPTH                   = 8,
  parameter int opcodeSize              = decode_pkg::OPCODE_SIZE,
  parameter int addressWidth            = decode_pkg::ADDRESS_WIDTH,
  parameter int funcUnitCodeSize        = decode_pkg::FUNC_UNIT_CODE_SIZE,
  parameter int instructionCounterWidth = decode_pkg::INSTRUCTION_COUNTER_WIDTH,
  parameter int instMinIdWidth          = decode_pkg::INST_MIN_ID_WIDTH,
  parameter int PidSize                 = decode_pkg::PID_SIZE,
  parameter int TidSize                 = decode_pkg::TID_SIZE,
  parameter int regSize                 = decode_pkg::REG_SIZE,
  parameter int regAccessPatternSize    = decode_pkg::REG_ACCESS_PATTERN_SIZE
);

  logic                               enable_i;
  logic [opcodeSize-1:0]              opcode_i;
  logic [addressWidth-1:0]            instructionAddress_i;
  logic [funcUnitCodeSize-1:0]        functionalUnitType_i;
  logic [instructionCounterWidth-1:0] instMajId_i;
  logic [instMinIdWidth-1:0]          instMinId_i;
  logic                               is64Bit_i;
  logic [PidSize-1:0]                 instPid_i;
  logic [TidSize-1:0]                 instTid_i;
  logic [regAccessPatternSize-1:0]    op1rw_i, op2rw_i, op3rw_i, op4rw_i;
  logic                               op1IsReg_i, op2IsReg_i, op3IsReg_i, op4IsReg_i;
  logic [4*regSize:0]                 instructionBody_i;
  logic                               flush_i;
  logic                               stall_i;

  logic                               stall_o;
  logic                               enable_o;
  logic [opcodeSize-1:0]              opcode_o;
  logic [addressWidth-1:0]            instructionAddress_o;
  logic [funcUnitCodeSize-1:0]        functionalUnitType_o;
  logic [instructionCounterWidth-1:0] instMajId_o;
  logic [instMinIdWidth-1:0]          instMinId_o;
  logic                               is64Bit_o;
  logic [PidSize-1:0]                 instPid_o;
  logic [TidSize-1:0]                 instTid_o;
  logic [regAccessPatternSize-1:0]    op1rw_o, op2rw_o, op3rw_o, op4rw_o;
  logic                               op1IsReg_o, op2IsReg_o, op3IsReg_o, op4IsReg_o;
  logic [4*regSize:0]                 instructionBody_o;
  logic [$clog2(DEPTH):0]             count_o;
  logic                               overflow_o;

  modport slave (
    input  enable_i, opcode_i, instructionAddress_i, functionalUnitType_i, instMajId_i,
           instMinId_i, is64Bit_i, instPid_i, instTid_i, op1rw_i, op2rw_i, op3rw_i,
           op4rw_i, op1IsReg_i, op2IsReg_i, op3IsReg_i, op4IsReg_i, instructionBody_i,
           flush_i, stall_i,
    output stall_o, enable_o, opcode_o, instructionAddress_o, functionalUnitType_o,
           instMajId_o, instMinId_o, is64Bit_o, instPid_o, instTid_o, op1rw_o, op2rw_o,
           op3rw_o, op4rw_o, op1IsReg_o, op2IsReg_o, op3IsReg_o, op4IsReg_o,
           instructionBody_o, count_o, overflow_o
  );

  modport master (
    output enable_i, opcode_i, instructionAddress_i, functionalUnitType_i, instMajId_i,
           instMinId_i, is64Bit_i, instPid_i, instTid_i, op1rw_i, op2rw_i, op3rw_i,
           op4rw_i, op1IsReg_i, op2IsReg_i, op3IsReg_i, op4IsReg_i, instructionBody_i,
           flush_i, stall_i,
    input  stall_o, enable_o, opcode_o, instructionAddress_o, functionalUnitType_o,
           instMajId_o, instMinId_o, is64Bit_o, instPid_o, instTid_o, op1rw_o, op2rw_o,
           op3rw_o, op4rw_o, op1IsReg_o, op2IsReg_o, op3IsReg_o, op4IsReg_o,
           instructionBody_o, count_o, overflow_o
  );

endinterface

// File: rtl/decode_fifo_storage.sv
// Entry storage for the decode output queue: one synchronous write port and one
// asynchronous read port so the head entry is visible with no added latency.
module decode_fifo_storage #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     clock_i,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Contents are meaningless until written; the top level masks empty reads.
  always_ff @(posedge clock_i) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/decode_output_queue.sv
// Show-ahead queue between the format decoders and issue: pointers, occupancy,
// skid back-pressure and sticky overflow live here, entries live in the storage.
module decode_output_queue
  import decode_pkg::*;
#(
  parameter int DEPTH                   = 8,
  parameter int opcodeSize              = OPCODE_SIZE,
  parameter int addressWidth            = ADDRESS_WIDTH,
  parameter int funcUnitCodeSize        = FUNC_UNIT_CODE_SIZE,
  parameter int instructionCounterWidth = INSTRUCTION_COUNTER_WIDTH,
  parameter int instMinIdWidth          = INST_MIN_ID_WIDTH,
  parameter int PidSize                 = PID_SIZE,
  parameter int TidSize                 = TID_SIZE,
  parameter int regSize                 = REG_SIZE,
  parameter int regAccessPatternSize    = REG_ACCESS_PATTERN_SIZE
) (
  input logic                  clock_i,
  input logic                  reset_i,
  decode_output_queue_if.slave q
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = AW + 1;
  localparam int REC_W = opcodeSize + addressWidth + funcUnitCodeSize
                       + instructionCounterWidth + instMinIdWidth + 1 + PidSize + TidSize
                       + 4*regAccessPatternSize + 4 + 4*regSize + 1;

  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic             overflow;
  logic             full, nonempty, push, pop, drop;
  logic [REC_W-1:0] wr_rec, rd_rec, head;

  assign full     = (count == CW'(DEPTH));
  assign nonempty = (count != '0);

  // A full queue still accepts when the head leaves on the same edge.
  assign pop  = nonempty && !q.stall_i && !q.flush_i;
  assign push = q.enable_i && !q.flush_i && (!full || pop);
  assign drop = q.enable_i && !q.flush_i && full && !pop;

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (drop) overflow <= 1'b1;
      if (q.flush_i) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
        if (push && !pop)      count <= count + CW'(1);
        else if (pop && !push) count <= count - CW'(1);
      end
    end
  end

  assign wr_rec = {q.opcode_i, q.instructionAddress_i, q.functionalUnitType_i,
                   q.instMajId_i, q.instMinId_i, q.is64Bit_i, q.instPid_i, q.instTid_i,
                   q.op1rw_i, q.op2rw_i, q.op3rw_i, q.op4rw_i,
                   q.op1IsReg_i, q.op2IsReg_i, q.op3IsReg_i, q.op4IsReg_i,
                   q.instructionBody_i};

  decode_fifo_storage #(
    .DEPTH (DEPTH),
    .WIDTH (REC_W)
  ) u_storage (
    .clock_i (clock_i),
    .we      (push),
    .waddr   (wr_ptr),
    .wdata   (wr_rec),
    .raddr   (rd_ptr),
    .rdata   (rd_rec)
  );

  // Unwritten storage is X; zeroing the empty head keeps X off the outputs.
  assign head = nonempty ? rd_rec : '0;

  assign {q.opcode_o, q.instructionAddress_o, q.functionalUnitType_o,
          q.instMajId_o, q.instMinId_o, q.is64Bit_o, q.instPid_o, q.instTid_o,
          q.op1rw_o, q.op2rw_o, q.op3rw_o, q.op4rw_o,
          q.op1IsReg_o, q.op2IsReg_o, q.op3IsReg_o, q.op4IsReg_o,
          q.instructionBody_o} = head;

  assign q.enable_o   = nonempty;
  assign q.stall_o    = (count >= CW'(DEPTH - 1));
  assign q.count_o    = count;
  assign q.overflow_o = overflow;

endmodule

// File: tb/tb_decode_output_queue.sv
// Directed bench for decode_output_queue: a queue-based reference model checked
// every cycle, plus literal expectations for the key scenarios.
module tb_decode_output_queue;
  import decode_pkg::*;

  localparam int DEPTH = 8;

  logic clock_i = 1'b0;
  logic reset_i = 1'b1;
  always #5 clock_i = ~clock_i;

  decode_output_queue_if #(.DEPTH(DEPTH)) q ();

  decode_output_queue #(.DEPTH(DEPTH)) dut (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .q       (q)
  );

  int vectors    = 0;
  int miscompares = 0;
  bit chk_on     = 1'b0;

  decode_inst_t in_rec, dut_head;
  decode_inst_t mq[$];
  bit           m_ovf = 1'b0;
  bit           m_pop, m_room;
  logic [63:0]  dut_log[$];
  logic [FUNC_UNIT_CODE_SIZE-1:0] fu_tab [6] = '{FU_FX, FU_FP, FU_VX, FU_CR, FU_LS, FU_BRANCH};

  always_comb in_rec = {q.opcode_i, q.instructionAddress_i, q.functionalUnitType_i,
                        q.instMajId_i, q.instMinId_i, q.is64Bit_i, q.instPid_i, q.instTid_i,
                        q.op1rw_i, q.op2rw_i, q.op3rw_i, q.op4rw_i,
                        q.op1IsReg_i, q.op2IsReg_i, q.op3IsReg_i, q.op4IsReg_i,
                        q.instructionBody_i};

  always_comb dut_head = {q.opcode_o, q.instructionAddress_o, q.functionalUnitType_o,
                          q.instMajId_o, q.instMinId_o, q.is64Bit_o, q.instPid_o, q.instTid_o,
                          q.op1rw_o, q.op2rw_o, q.op3rw_o, q.op4rw_o,
                          q.op1IsReg_o, q.op2IsReg_o, q.op3IsReg_o, q.op4IsReg_o,
                          q.instructionBody_o};

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: a plain FIFO of records with drop-on-full and sticky overflow.
  initial forever begin
    @(posedge clock_i or posedge reset_i);
    if (reset_i) begin
      mq.delete();
      m_ovf = 1'b0;
    end else if (q.flush_i) begin
      mq.delete();
    end else begin
      m_pop  = (mq.size() > 0) && !q.stall_i;
      m_room = (mq.size() < DEPTH) || m_pop;
      if (m_pop) void'(mq.pop_front());
      if (q.enable_i) begin
        if (m_room) mq.push_back(in_rec);
        else m_ovf = 1'b1;
      end
    end
  end

  initial forever begin
    @(negedge clock_i);
    if (chk_on && !reset_i) begin
      check("count", q.count_o, mq.size());
      check("enable", q.enable_o, mq.size() > 0);
      check("stall", q.stall_o, mq.size() >= DEPTH - 1);
      check("overflow", q.overflow_o, m_ovf);
      if (mq.size() > 0) check("head", dut_head, mq[0]);
      else check("no_x", $isunknown(dut_head), 0);
    end
  end

  function automatic decode_inst_t mk(input logic [63:0] id);
    logic [223:0] raw;
    decode_inst_t r;
    raw = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    r = raw[DECODE_INST_W-1:0];
    r.inst_maj_id = id;
    r.functional_unit_type = fu_tab[$urandom_range(0, 5)];
    return r;
  endfunction

  task automatic step(input bit en, input logic [63:0] id, input bit st, input bit fl);
    decode_inst_t r;
    r = mk(id);
    q.enable_i             = en;
    q.opcode_i             = r.opcode;
    q.instructionAddress_i = r.instruction_address;
    q.functionalUnitType_i = r.functional_unit_type;
    q.instMajId_i          = r.inst_maj_id;
    q.instMinId_i          = r.inst_min_id;
    q.is64Bit_i            = r.is_64bit;
    q.instPid_i            = r.inst_pid;
    q.instTid_i            = r.inst_tid;
    q.op1rw_i              = r.op1_rw;
    q.op2rw_i              = r.op2_rw;
    q.op3rw_i              = r.op3_rw;
    q.op4rw_i              = r.op4_rw;
    q.op1IsReg_i           = r.op1_is_reg;
    q.op2IsReg_i           = r.op2_is_reg;
    q.op3IsReg_i           = r.op3_is_reg;
    q.op4IsReg_i           = r.op4_is_reg;
    q.instructionBody_i    = r.instruction_body;
    q.stall_i              = st;
    q.flush_i              = fl;
    @(posedge clock_i);
    @(negedge clock_i);
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    q.enable_i = 1'b0;
    q.flush_i  = 1'b0;
    q.stall_i  = 1'b0;
    @(posedge clock_i);
    @(negedge clock_i);
    reset_i = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent;
    bit st, en;
    q.enable_i = 1'b0;
    q.flush_i  = 1'b0;
    q.stall_i  = 1'b0;
    repeat (2) @(negedge clock_i);
    reset_i = 1'b0;
    chk_on  = 1'b1;
    check("rst_count", q.count_o, 0);
    check("rst_enable", q.enable_o, 0);
    check("rst_payload", dut_head, 0);

    // Pass-through: each entry is the head for exactly one cycle.
    step(1, 5, 0, 0);
    check("s1_head5", q.instMajId_o, 5);
    check("s1_count", q.count_o, 1);
    step(1, 6, 0, 0);
    check("s1_head6", q.instMajId_o, 6);
    check("s1_count", q.count_o, 1);
    step(1, 7, 0, 0);
    check("s1_head7", q.instMajId_o, 7);
    check("s1_count", q.count_o, 1);
    step(0, 0, 0, 0);
    check("s1_empty", q.enable_o, 0);

    // Fill under stall, then overflow.
    for (int i = 0; i < 6; i++) step(1, 10 + i, 1, 0);
    check("s2_count6", q.count_o, 6);
    check("s2_stall_low", q.stall_o, 0);
    step(1, 16, 1, 0);
    check("s2_count7", q.count_o, 7);
    check("s2_stall_high", q.stall_o, 1);
    step(1, 17, 1, 0);
    check("s2_count8", q.count_o, 8);
    check("s2_no_ovf", q.overflow_o, 0);
    step(1, 18, 1, 0);
    check("s2_ovf", q.overflow_o, 1);
    check("s2_count_hold", q.count_o, 8);
    check("s2_head", q.instMajId_o, 10);
    do_reset();
    @(negedge clock_i);
    check("s2_ovf_cleared", q.overflow_o, 0);

    // Full queue with push and pop together.
    for (int i = 0; i < 8; i++) step(1, 100 + i, 1, 0);
    step(1, 108, 0, 0);
    check("s3_count", q.count_o, 8);
    check("s3_head", q.instMajId_o, 101);
    check("s3_ovf", q.overflow_o, 0);

    // Flush beats a simultaneous push.
    step(0, 0, 0, 1);
    check("s4_flush0", q.count_o, 0);
    for (int i = 0; i < 5; i++) step(1, 200 + i, 1, 0);
    check("s4_count5", q.count_o, 5);
    step(1, 250, 0, 1);
    check("s4_count", q.count_o, 0);
    check("s4_enable", q.enable_o, 0);
    step(1, 300, 0, 0);
    check("s4_after", q.instMajId_o, 300);
    step(0, 0, 0, 0);

    // 20 entries with random stall, honouring stall_o.
    sent = 0;
    dut_log.delete();
    for (int c = 0; c < 400 && sent < 20; c++) begin
      st = 1'($urandom_range(0, 1));
      en = !q.stall_o;
      if (q.enable_o && !st) dut_log.push_back(q.instMajId_o);
      step(en, 64'(400 + sent), st, 0);
      if (en) sent++;
    end
    check("s5_sent", sent, 20);
    for (int c = 0; c < 50 && q.count_o != 0; c++) begin
      if (q.enable_o) dut_log.push_back(q.instMajId_o);
      step(0, 0, 0, 0);
    end
    check("s5_drained", q.count_o, 0);
    check("s5_popped", dut_log.size(), 20);
    for (int i = 0; i < dut_log.size() && i < 20; i++) check("s5_order", dut_log[i], 400 + i);

    // Asynchronous reset in the middle of a burst.
    for (int i = 0; i < 3; i++) step(1, 600 + i, 1, 0);
    @(posedge clock_i);
    #2;
    reset_i = 1'b1;
    #1;
    check("s6_count", q.count_o, 0);
    check("s6_enable", q.enable_o, 0);
    check("s6_stall", q.stall_o, 0);
    check("s6_ovf", q.overflow_o, 0);
    check("s6_payload", dut_head, 0);
    q.enable_i = 1'b0;
    @(negedge clock_i);
    reset_i = 1'b0;
    step(1, 500, 0, 0);
    check("s6_first", q.instMajId_o, 500);
    check("s6_first_count", q.count_o, 1);
    step(0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/decode_output_queue.md
DECODE_OUTPUT_QUEUE -- requirements
Module: decode_output_queue

Interface
REQ-001 Clocking SHALL use one clock and an asynchronous, active-high reset, with ports named clock_i and reset_i.
REQ-002 Parameters SHALL be as follows, one per line (name, default, meaning):
- DEPTH, 8, number of entries; power of two, at least 4.
- opcodeSize, 12, width of the decoded opcode.
- addressWidth, 64, width of the instruction address.
- funcUnitCodeSize, 3, width of the functional-unit code.
- instructionCounterWidth, 64, width of the major ID.
- instMinIdWidth, 7, width of the minor ID.
- PidSize / TidSize, 20 / 16, widths of the process and thread IDs.
- regSize, 5, width of a register field.
- regAccessPatternSize, 2, width of each operand read/write flag.
REQ-003 Ports SHALL be as follows, one per line (name, direction, width, meaning):
- clock_i, in, 1, clock.
- reset_i, in, 1, asynchronous active-high reset.
- enable_i, in, 1, a decoded instruction is present this cycle.
- opcode_i, in, opcodeSize, decoded opcode.
- instructionAddress_i, in, addressWidth, instruction address.
- functionalUnitType_i, in, funcUnitCodeSize, target functional unit.
- instMajId_i, in, instructionCounterWidth, major ID.
- instMinId_i, in, instMinIdWidth, minor ID.
- is64Bit_i, in, 1, 64-bit mode.
- instPid_i / instTid_i, in, PidSize / TidSize, process and thread IDs.
- op1rw_i..op4rw_i, in, 2 each, operand read/write flags.
- op1IsReg_i..op4IsReg_i, in, 1 each, operand is a register.
- instructionBody_i, in, 4*regSize+1, operand fields.
- flush_i, in, 1, discard every entry.
- stall_i, in, 1, downstream cannot accept.
- stall_o, out, 1, back-pressure to the format decoders.
- enable_o, out, 1, head entry is valid.
- All payload fields, out, widths as the matching inputs, same names with suffix _o, head-entry payload.
- count_o, out, log2(DEPTH)+1, number of occupied entries.
- overflow_o, out, 1, sticky flag set when an entry is dropped.

Function
REQ-004 The queue SHALL be a show-ahead FIFO: whenever count is greater than 0, enable_o is 1 and the payload outputs present the oldest entry with zero added latency.
REQ-005 A push SHALL occur on a rising edge when enable_i is 1, no flush is requested, and either count is less than DEPTH or a pop occurs on the same edge.
REQ-006 A pop SHALL occur on a rising edge when enable_o is 1, stall_i is 0 and flush_i is 0.
REQ-007 A simultaneous push and pop SHALL leave count unchanged, including when the queue is full or holds exactly one entry; when one entry is held, the new entry becomes the head on the next cycle.
REQ-008 stall_o SHALL equal (count >= DEPTH-1), derived from registered state only; this provides a one-entry skid slot that absorbs the format decoders' one-cycle latency.
REQ-009 When enable_i is 1, the queue is full (count == DEPTH) and no pop occurs, the entry SHALL be dropped and overflow_o SHALL set, remaining set until reset.
REQ-010 flush_i SHALL, on the next edge, clear count and both pointers, take priority over a simultaneous push or pop, and leave overflow_o unchanged.
REQ-011 The read and write pointers SHALL wrap modulo DEPTH, and count SHALL never exceed DEPTH or underflow.
REQ-012 Entries SHALL leave the queue in arrival order, with every payload bit unchanged.
REQ-013 When enable_o is 0, the payload outputs are don't-care, but SHALL NOT contain X after reset.

Reset
REQ-014 Asserting reset_i SHALL asynchronously clear count_o, both pointers and overflow_o, and drive enable_o and stall_o to 0 and every payload output to 0.
REQ-015 A reset asserted mid-operation SHALL discard every entry, and the first push after release SHALL appear on the outputs in the following cycle.

Structure
REQ-016 A shared package decode_pkg SHALL hold the width constants, the functional-unit ID constants (FX=0, FP=1, VX=2, CR=3, LS=4, Branch=6) and the packed decoded-instruction record type.
REQ-017 The storage array SHALL be a sub-module decode_fifo_storage (DEPTH by record width, one write port, one asynchronous read port); pointer, count, stall and overflow logic SHALL stay in the top level.

Verification
REQ-018 The bench SHALL cover the following directed scenarios:
- Push 3 entries with major IDs 5, 6, 7 while stall_i=0 -> enable_o is 1 in the cycle after each push and entries emerge 5, 6, 7; count_o peaks at most 1.
- Hold stall_i=1 and push 7 entries -> stall_o rises when count_o=7; one further push gives count_o=8 with no overflow; a ninth push sets overflow_o and count_o stays 8.
- With the queue full and stall_i=0, push and pop together -> count_o stays 8, the head advances and overflow_o stays 0.
- Fill 5 entries, then assert flush_i together with enable_i -> count_o=0 and enable_o=0 on the next cycle, and the new entry is discarded.
- Push 20 entries with random stall_i -> the output order matches the input order, exercising pointer wrap.
- Assert reset_i asynchronously mid-burst -> all outputs are 0 before the next clock edge.
